// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, framer state encoding and the
// reflected CRC-32 byte step used by the transmit and receive paths.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam int          HDR_BYTES     = 14;
    localparam int          FCS_BYTES     = 4;
    localparam int          PKTBUF_DEPTH  = 1518;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_RING,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } framer_state_t;

    // LSB-first: data bit 0 is folded in first, matching the wire order.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mac_tx_framer_crc.sv
// Combinational single-byte CRC-32 step; also reused by the receive-side
// FCS checker.
module crc32_byte_update
    import eth_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    assign o_crc = crc32_byte(i_crc, i_data);

endmodule

// File: rtl/mac_tx_framer.sv
// Assembles preamble, header, payload, pad and FCS into the shared packet
// buffer, then hands the buffer to the serializer through a doorbell.
module mac_tx_framer
    import eth_pkg::*;
#(
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1492
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] i_dst_mac,
    input  logic [47:0] i_src_mac,
    input  logic [15:0] i_ethertype,
    input  logic [7:0]  i_s_axis_tdata,
    input  logic        i_s_axis_tvalid,
    input  logic        i_s_axis_tlast,
    output logic        o_s_axis_tready,
    output logic [7:0]  o_pktbuf [PKTBUF_DEPTH],
    output logic [10:0] o_pktbuf_maxaddr,
    output logic        o_doorbell,
    input  logic        i_available,
    output logic        o_busy,
    output logic        o_err_oversize
);

    localparam logic [10:0] MIN_P    = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_P    = 11'(MAX_PAYLOAD);
    localparam logic [10:0] HDR_LAST = 11'(8 + HDR_BYTES - 1);
    localparam logic [1:0]  FCS_LAST = 2'(FCS_BYTES - 1);

    framer_state_t r_state;
    framer_state_t w_next_state;

    logic [10:0]  r_widx;
    logic [10:0]  r_plen;
    logic [1:0]   r_fidx;
    logic [31:0]  r_crc;
    logic [111:0] r_hdr;
    logic         r_ovf_seen;
    logic         r_err_oversize;
    logic [10:0]  r_maxaddr;
    logic [7:0]   r_pktbuf [PKTBUF_DEPTH];

    logic [31:0] w_crc_next;
    logic [31:0] w_fcs;
    logic [7:0]  w_wdata;
    logic        w_we;
    logic        w_crc_en;
    logic        w_start;
    logic        w_keep;
    logic        w_drop;
    logic        w_plen_inc;
    logic        w_hdr_shift;
    logic        w_fcs_last;

    crc32_byte_update u_crc (
        .i_crc  (r_crc),
        .i_data (w_wdata),
        .o_crc  (w_crc_next)
    );

    assign w_fcs = ~r_crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        o_s_axis_tready = 1'b0;
        o_doorbell      = 1'b0;
        w_we            = 1'b0;
        w_crc_en        = 1'b0;
        w_wdata         = 8'h00;
        w_start         = 1'b0;
        w_keep          = 1'b0;
        w_drop          = 1'b0;
        w_plen_inc      = 1'b0;
        w_hdr_shift     = 1'b0;
        w_fcs_last      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_s_axis_tvalid) begin
                    w_start      = 1'b1;
                    w_next_state = ST_HDR;
                end
            end
            ST_HDR: begin
                w_we = 1'b1;
                if (r_widx < 11'd7) begin
                    w_wdata = ETH_PREAMBLE;
                end else if (r_widx == 11'd7) begin
                    w_wdata = ETH_SFD;
                end else begin
                    w_wdata     = r_hdr[111:104];
                    w_crc_en    = 1'b1;
                    w_hdr_shift = 1'b1;
                end
                if (r_widx == HDR_LAST) begin
                    w_next_state = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                o_s_axis_tready = 1'b1;
                if (i_s_axis_tvalid) begin
                    // Beats past the cap are still consumed so the source drains.
                    if (r_plen < MAX_P) begin
                        w_keep     = 1'b1;
                        w_plen_inc = 1'b1;
                        w_we       = 1'b1;
                        w_crc_en   = 1'b1;
                        w_wdata    = i_s_axis_tdata;
                    end else begin
                        w_drop = 1'b1;
                    end
                    if (i_s_axis_tlast) begin
                        if ((r_plen + {10'd0, w_keep}) < MIN_P) begin
                            w_next_state = ST_PAD;
                        end else begin
                            w_next_state = ST_FCS;
                        end
                    end
                end
            end
            ST_PAD: begin
                w_we       = 1'b1;
                w_crc_en   = 1'b1;
                w_plen_inc = 1'b1;
                if (r_plen == (MIN_P - 11'd1)) begin
                    w_next_state = ST_FCS;
                end
            end
            ST_FCS: begin
                w_we = 1'b1;
                case (r_fidx)
                    2'd0:    w_wdata = w_fcs[7:0];
                    2'd1:    w_wdata = w_fcs[15:8];
                    2'd2:    w_wdata = w_fcs[23:16];
                    default: w_wdata = w_fcs[31:24];
                endcase
                if (r_fidx == FCS_LAST) begin
                    w_fcs_last   = 1'b1;
                    w_next_state = ST_RING;
                end
            end
            ST_RING: begin
                if (i_available) begin
                    o_doorbell   = 1'b1;
                    w_next_state = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (!i_available) begin
                    w_next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_available) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Header fields are captured once and shifted out MSB byte first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_widx         <= 11'd0;
            r_plen         <= 11'd0;
            r_fidx         <= 2'd0;
            r_crc          <= 32'd0;
            r_hdr          <= 112'd0;
            r_ovf_seen     <= 1'b0;
            r_err_oversize <= 1'b0;
            r_maxaddr      <= 11'd0;
        end else begin
            r_err_oversize <= 1'b0;
            if (w_start) begin
                r_hdr      <= {i_dst_mac, i_src_mac, i_ethertype};
                r_widx     <= 11'd0;
                r_plen     <= 11'd0;
                r_fidx     <= 2'd0;
                r_crc      <= CRC32_INIT;
                r_ovf_seen <= 1'b0;
            end
            if (w_hdr_shift) begin
                r_hdr <= {r_hdr[103:0], 8'h00};
            end
            if (w_crc_en) begin
                r_crc <= w_crc_next;
            end
            if (w_we) begin
                r_widx <= r_widx + 11'd1;
            end
            if (w_plen_inc) begin
                r_plen <= r_plen + 11'd1;
            end
            if (r_state == ST_FCS) begin
                r_fidx <= r_fidx + 2'd1;
            end
            if (w_fcs_last) begin
                r_maxaddr <= r_widx;
            end
            if (w_drop && !r_ovf_seen) begin
                r_ovf_seen     <= 1'b1;
                r_err_oversize <= 1'b1;
            end
        end
    end

    // Buffer contents are don't-care until the first doorbell, so no reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_pktbuf[r_widx] <= w_wdata;
        end
    end

    assign o_pktbuf         = r_pktbuf;
    assign o_pktbuf_maxaddr = r_maxaddr;
    assign o_busy           = (r_state != ST_IDLE);
    assign o_err_oversize   = r_err_oversize;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Self-checking bench for mac_tx_framer: random frames compared against a
// byte-list frame model with a bit-serial CRC-32 reference.
`timescale 1ns/1ps
module tb_mac_tx_framer;

    localparam int DEPTH = 1518;
    localparam int MINP  = 46;
    localparam int MAXP  = 1492;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] dstMac = '0;
    logic [47:0] srcMac = '0;
    logic [15:0] etherType = '0;
    logic [7:0]  tData = '0;
    logic        tValid = 1'b0;
    logic        tLast = 1'b0;
    logic        tReady;
    logic [7:0]  pktBuf [DEPTH];
    logic [10:0] pktMaxaddr;
    logic        doorbell;
    logic        available = 1'b1;
    logic        busy;
    logic        errOversize;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int dbCount = 0;
    int errCount = 0;
    int busyRiseCyc = 0;
    logic prevBusy = 1'b0;

    logic [47:0] hD, hS;
    logic [15:0] hT;
    logic [7:0]  payQ [$];
    logic [7:0]  expFrame [DEPTH];
    int          expLen = 0;

    mac_tx_framer dut (
        .clk              (clk),
        .rst              (rst),
        .i_dst_mac        (dstMac),
        .i_src_mac        (srcMac),
        .i_ethertype      (etherType),
        .i_s_axis_tdata   (tData),
        .i_s_axis_tvalid  (tValid),
        .i_s_axis_tlast   (tLast),
        .o_s_axis_tready  (tReady),
        .o_pktbuf         (pktBuf),
        .o_pktbuf_maxaddr (pktMaxaddr),
        .o_doorbell       (doorbell),
        .i_available      (available),
        .o_busy           (busy),
        .o_err_oversize   (errOversize)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (doorbell) dbCount <= dbCount + 1;
        if (errOversize) errCount <= errCount + 1;
        if (busy && !prevBusy) busyRiseCyc <= cyc;
        prevBusy <= busy;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ b[k];
            r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
        end
        return r;
    endfunction

    task automatic driveHeader(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
        dstMac = d;
        srcMac = s;
        etherType = t;
    endtask

    task automatic newHeader();
        hD = {16'($urandom), 32'($urandom)};
        hS = {16'($urandom), 32'($urandom)};
        hT = 16'($urandom);
        driveHeader(hD, hS, hT);
    endtask

    // Expected frame as a flat byte list built from the framing rules.
    task automatic buildExpected();
        logic [7:0]  f [$];
        logic [31:0] c;
        int          keep;
        f = {};
        repeat (7) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 0; i < 6; i++) f.push_back(hD[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(hS[47-8*i -: 8]);
        f.push_back(hT[15:8]);
        f.push_back(hT[7:0]);
        keep = (payQ.size() > MAXP) ? MAXP : payQ.size();
        for (int i = 0; i < keep; i++) f.push_back(payQ[i]);
        while (f.size() < 8 + 14 + MINP) f.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < f.size(); i++) c = crcStep(c, f[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
        expLen = f.size();
        for (int i = 0; i < expLen; i++) expFrame[i] = f[i];
    endtask

    task automatic checkFrame(input string name);
        int          nbad;
        int          first;
        logic [31:0] res;
        nbad = 0;
        first = -1;
        for (int i = 0; i < expLen; i++) begin
            if (pktBuf[i] !== expFrame[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        checkOutput({name, " maxaddr"}, 32'(pktMaxaddr), 32'(expLen - 1));
        checkOutput($sformatf("%s bad bytes (first at %0d)", name, first), 32'(nbad), 32'd0);
        res = 32'hFFFFFFFF;
        for (int i = 8; i <= int'(pktMaxaddr) && i < DEPTH; i++) res = crcStep(res, pktBuf[i]);
        checkOutput({name, " crc residue"}, res, 32'hDEBB20E3);
    endtask

    task automatic applyStimulus(input int n, input bit toggle, input int abortAt,
                                 input bit ramp, output int accepted);
        int guard;
        bit ph;
        bit scrambled;
        payQ = {};
        for (int i = 0; i < n; i++) payQ.push_back(ramp ? 8'(i) : 8'($urandom));
        accepted = 0;
        guard = 0;
        ph = 1'b1;
        scrambled = 1'b0;
        while (accepted < n && guard < 4000) begin
            @(posedge clk);
            #1;
            if (abortAt >= 0 && accepted == abortAt) return;
            tValid = toggle ? ph : 1'b1;
            ph = !ph;
            tData = payQ[accepted];
            tLast = (accepted == n - 1);
            @(negedge clk);
            if (tValid && tReady) accepted++;
            if (accepted > 0 && !scrambled) begin
                driveHeader({16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)}, 16'($urandom));
                scrambled = 1'b1;
            end
            guard++;
        end
        @(posedge clk);
        #1;
        tValid = 1'b0;
        tLast = 1'b0;
    endtask

    task automatic waitDoorbell(input string name);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!doorbell && g < 200);
        checkOutput({name, " doorbell seen"}, 32'(doorbell), 32'd1);
    endtask

    // Plays the serializer: drop available two cycles after the doorbell,
    // hold it low, then release the buffer.
    task automatic ackAndRelease(input int hold, input bit overlap, input int db0, input string name);
        repeat (2) @(posedge clk);
        #1;
        available = 1'b0;
        if (overlap) begin
            driveHeader({16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)}, 16'($urandom));
            tValid = 1'b1;
            tData = 8'hA5;
            tLast = 1'b0;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (overlap) checkOutput({name, " tready while busy"}, 32'(tReady), 32'd0);
        end
        checkFrame({name, " held"});
        checkOutput({name, " busy while serializing"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        available = 1'b1;
        if (overlap) newHeader();
        @(negedge clk);
        checkOutput({name, " busy before release edge"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput({name, " busy released"}, 32'(busy), 32'd0);
        checkOutput({name, " doorbell count"}, 32'(dbCount - db0), 32'd1);
    endtask

    task automatic runFrame(input int n, input bit toggle, input bit ramp, input bit overlap, input string name);
        int acc;
        int db0;
        int e0;
        int lat;
        db0 = dbCount;
        e0 = errCount;
        applyStimulus(n, toggle, -1, ramp, acc);
        checkOutput({name, " beats accepted"}, 32'(acc), 32'(n));
        buildExpected();
        waitDoorbell(name);
        if (!toggle) begin
            lat = 22 + n + ((n < MINP) ? (MINP - n) : 0) + 4;
            checkOutput({name, " doorbell latency"}, 32'(cyc - busyRiseCyc), 32'(lat));
        end
        checkFrame(name);
        checkOutput({name, " oversize pulses"}, 32'(errCount - e0), (n > MAXP) ? 32'd1 : 32'd0);
        ackAndRelease(3, overlap, db0, name);
    endtask

    initial begin
        int acc;
        int db0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset tready", 32'(tReady), 32'd0);
        checkOutput("reset doorbell", 32'(doorbell), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset err_oversize", 32'(errOversize), 32'd0);
        checkOutput("reset maxaddr", 32'(pktMaxaddr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Broadcast frame with a short ramp payload, padded to minimum
        hD = 48'hFFFF_FFFF_FFFF;
        hS = 48'h0200_0000_0001;
        hT = 16'h0800;
        driveHeader(hD, hS, hT);
        runFrame(10, 1'b0, 1'b1, 1'b0, "t1");

        // Gapped payload stream, no padding
        newHeader();
        runFrame(100, 1'b1, 1'b0, 1'b0, "t2");

        // Oversize payload: cap at the buffer depth
        newHeader();
        runFrame(1500, 1'b0, 1'b0, 1'b0, "t3");

        // Serializer not available when the frame completes
        newHeader();
        @(posedge clk);
        #1;
        available = 1'b0;
        db0 = dbCount;
        applyStimulus(60, 1'b0, -1, 1'b0, acc);
        checkOutput("t4 beats accepted", 32'(acc), 32'd60);
        buildExpected();
        repeat (80) @(negedge clk);
        checkOutput("t4 no doorbell while unavailable", 32'(dbCount - db0), 32'd0);
        checkFrame("t4 ring");
        @(posedge clk);
        #1;
        available = 1'b1;
        @(negedge clk);
        checkOutput("t4 doorbell on available", 32'(doorbell), 32'd1);
        @(negedge clk);
        checkOutput("t4 doorbell single cycle", 32'(doorbell), 32'd0);
        ackAndRelease(6, 1'b0, db0, "t4");

        // Next frame already waiting while the buffer is still busy
        newHeader();
        runFrame(30, 1'b0, 1'b0, 1'b1, "t5a");
        runFrame(50, 1'b0, 1'b0, 1'b0, "t5b");

        // Reset in the middle of the payload phase
        newHeader();
        db0 = dbCount;
        applyStimulus(60, 1'b0, 20, 1'b0, acc);
        #2;
        rst = 1'b1;
        #2;
        checkOutput("t6 async busy", 32'(busy), 32'd0);
        checkOutput("t6 async tready", 32'(tReady), 32'd0);
        checkOutput("t6 async doorbell", 32'(doorbell), 32'd0);
        checkOutput("t6 async maxaddr", 32'(pktMaxaddr), 32'd0);
        checkOutput("t6 async err_oversize", 32'(errOversize), 32'd0);
        tValid = 1'b0;
        tLast = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("t6 no doorbell after abort", 32'(dbCount - db0), 32'd0);
        newHeader();
        runFrame(46, 1'b0, 1'b0, 1'b0, "t6 post");

        for (int i = 0; i < 4; i++) begin
            newHeader();
            runFrame(int'($urandom_range(1, 120)), 1'($urandom_range(0, 1)), 1'b0, 1'b0,
                     $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mac_tx_framer.md
Name: mac_tx_framer

Overview:
Builds a complete Ethernet frame in the shared transmit packet buffer, then rings the downstream transmit interface's doorbell. It accepts payload bytes on a byte-wide valid/ready stream and fills the buffer in order: preamble, SFD, destination MAC, source MAC, ethertype, payload, zero pad and FCS. It sits directly upstream of the dibit serializer (mac_tx_ifc), which drives the buffer onto the RMII-side stream. The buffer is single and the block does not pipeline frames: it holds the buffer stable until the serializer reports available again.

Parameters:
MIN_PAYLOAD, 46, pad target in bytes; frames with a shorter payload are zero-padded up to this length.
MAX_PAYLOAD, 1492, payload cap in bytes; 8+14+1492+4 = 1518 equals the buffer depth.

Ports:
clk  in  1  system clock (50 MHz RMII domain).
rst  in  1  asynchronous, active-high reset.
dst_mac  in  48  destination MAC, byte [47:40] sent first; latched at frame start.
src_mac  in  48  source MAC, same byte order as dst_mac; latched at frame start.
ethertype  in  16  [15:8] sent first; latched at frame start.
s_axis_tdata  in  8  payload byte.
s_axis_tvalid  in  1  payload byte valid.
s_axis_tlast  in  1  marks the final payload byte.
s_axis_tready  out  1  framer accepts the byte this cycle.
pktbuf  out  8x[1517:0]  frame bytes, index 0 first on the wire.
pktbuf_maxaddr  out  11  index of the last valid byte (total length - 1).
doorbell  out  1  single-cycle request to the serializer to start transmitting.
available  in  1  serializer idle and ready for a doorbell.
busy  out  1  high from frame start until the serializer releases the buffer.
err_oversize  out  1  one-cycle pulse when payload bytes are dropped.

Behaviour:
- Reset, asynchronous: state IDLE; s_axis_tready=0, doorbell=0, busy=0, err_oversize=0, pktbuf_maxaddr=0. Counters and CRC are cleared. pktbuf contents are not reset and are don't-care until the first doorbell.
- IDLE: s_axis_tready=0. When s_axis_tvalid=1, latch dst_mac, src_mac and ethertype, set busy=1, widx=0, CRC=0xFFFFFFFF, then go to HDR. The pending payload byte stays on the bus untouched.
- HDR: writes one byte per cycle, 22 cycles, to indices 0-21.
  - Indices 0-6 = 0x55, index 7 = 0xD5.
  - Indices 8-21 = dst_mac, src_mac, ethertype in that order; these 14 bytes feed the CRC.
  - s_axis_tready=0 throughout. After index 21, go to PAYLOAD.
- PAYLOAD: s_axis_tready=1. Each accepted beat (tvalid & tready):
  - Writes pktbuf[widx], updates the CRC, increments widx and plen.
  - Once plen==MAX_PAYLOAD, further beats are still accepted but discarded (no write, no CRC update) and err_oversize pulses once for the frame.
  - The beat with tlast=1 ends the phase: go to PAD if plen after the beat < MIN_PAYLOAD, else go to FCS.
  - Gaps in tvalid are legal and simply stall the phase.
- PAD: s_axis_tready=0. Write 0x00 (CRC updated) one byte per cycle until plen==MIN_PAYLOAD.
- FCS: 4 cycles. Write ~CRC bytes [7:0], [15:8], [23:16], [31:24] in that order.
  - CRC is reflected CRC-32: poly 0xEDB88320, init all ones, LSB-first, matching the serializer's [1:0]-first dibit order.
  - On the last FCS cycle, register pktbuf_maxaddr = widx (index of the final FCS byte), then go to RING.
- RING: wait for available=1, then assert doorbell for exactly one cycle and go to WAIT_ACK.
- WAIT_ACK: wait for available=0. The serializer drops available 2 cycles after the doorbell. Then go to WAIT_DONE.
- WAIT_DONE: wait for available=1, then busy=0 and go to IDLE.
- pktbuf and pktbuf_maxaddr must not change from RING through WAIT_DONE.
- Frame length = 8+14+max(P,46)+4 bytes; minimum 72 (maxaddr 71), maximum 1518 (maxaddr 1517).
- Latency from start (tvalid with continuous input and available=1): 22 + P + pad + 4 cycles to reach RING, plus 1 cycle to the doorbell.
- Empty payload is not representable: the first beat always counts as one byte.
- Reset mid-frame: abort immediately; any frame in progress is lost and no doorbell is issued.

Decomposition:
- eth_pkg holds:
  - constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, HDR_BYTES=14, FCS_BYTES=4, PKTBUF_DEPTH=1518, CRC32_POLY, CRC32_INIT and CRC32_RESIDUE=32'hDEBB20E3;
  - the framer state enum;
  - a pure function crc32_byte(crc, byte).
- One sub-module, crc32_byte_update: a combinational single-byte step around crc32_byte, instantiated once. It is shared later by the receive-side FCS checker.

Test Plan:
- dst=FF:FF:FF:FF:FF:FF, src=02:00:00:00:00:01, type=0x0800, 10-byte payload 0x00..0x09 -> maxaddr=71; bytes 32-67 = 0x00; CRC over bytes 8-71 leaves register residue 0xDEBB20E3; exactly one doorbell.
- 100-byte payload with tvalid toggling every other cycle -> maxaddr=125, payload intact at indices 22-121, no pad; doorbell arrives 1 cycle after the final FCS write when available=1.
- 1500-byte payload -> maxaddr=1517, bytes 22-1513 = first 1492 bytes; one err_oversize pulse; all 1500 beats accepted.
- available held at 0 during RING -> doorbell stays low; raise available -> doorbell high for exactly 1 cycle; pktbuf stable until available returns to 1; only then busy=0.
- Second frame presented with tvalid=1 while busy -> s_axis_tready=0 until IDLE; its header latched only after busy falls.
- Assert rst during PAYLOAD -> all outputs take their reset values without waiting for clk; no doorbell; next frame builds correctly.
